// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, 4*N little-endian instruction bytes, XOR checksum.
// Writes each assembled word to instruction memory and releases the core on a good checksum.
module program_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  count;
  logic [7:0]  word_cnt;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_q;
  logic        xfer;

  // Next-state decode; DONE and ERROR are terminal until reset.
  always_comb begin
    state_nxt = state;
    xfer      = in_valid && in_ready;
    case (state)
      IDLE:    if (xfer) state_nxt = (in_data == 8'd0) ? ERROR : LOAD;
      LOAD:    if (xfer && byte_idx == 2'd3 && (word_cnt + 8'd1) == count) state_nxt = CHECK;
      CHECK:   if (xfer) state_nxt = (in_data == csum) ? DONE : ERROR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs, the latter decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 8'd0;
      word_cnt <= 8'd0;
      csum     <= 8'd0;
      byte_idx <= 2'd0;
      word_q   <= 24'd0;
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      im_addr  <= ADDR_W'(START_ADDR);
      im_wdata <= 32'd0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_ready <= (state_nxt == IDLE) || (state_nxt == LOAD) || (state_nxt == CHECK);
      done     <= (state_nxt == DONE);
      err      <= (state_nxt == ERROR);
      core_rst <= (state_nxt != DONE);
      im_we    <= 1'b0;
      if (im_we) im_addr <= im_addr + ADDR_W'(1);
      if (xfer) begin
        case (state)
          IDLE: begin
            count    <= in_data;
            word_cnt <= 8'd0;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
            im_addr  <= ADDR_W'(START_ADDR);
          end
          LOAD: begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_q[7:0]   <= in_data;
              2'd1: word_q[15:8]  <= in_data;
              2'd2: word_q[23:16] <= in_data;
              default: begin
                im_wdata <= {in_data, word_q};
                im_we    <= 1'b1;
                word_cnt <= word_cnt + 8'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a stream-level model predicts every memory write
// (word, offset, cycle) and the final outcome; two instances cover START_ADDR 0 and 0xFE.
module tb_program_loader;

  typedef struct {
    logic [31:0] word;
    int          rel;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        ready0, we0, crst0, done0, err0;
  logic        ready1, we1, crst1, done1, err1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nwrites = 0;
  bit          run = 0;
  logic [7:0]  last_addr0, last_addr1;
  logic [7:0]  stream[$];
  exp_t        q[$];
  logic [39:0] wlog[$];

  program_loader #(.ADDR_W(8), .START_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
    .im_we(we0), .im_addr(addr0), .im_wdata(wdata0), .core_rst(crst0), .done(done0), .err(err0));

  program_loader #(.ADDR_W(8), .START_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
    .im_we(we1), .im_addr(addr1), .im_wdata(wdata1), .core_rst(crst1), .done(done1), .err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle check: writes only where the model predicts them, nothing elsewhere.
  always @(negedge clk) begin
    if (run) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("we0", 32'(we0), 32'd1);
        chk("we1", 32'(we1), 32'd1);
        chk("wdata0", wdata0, e.word);
        chk("wdata1", wdata1, e.word);
        chk("addr0", 32'(addr0), 32'(8'(e.rel)));
        chk("addr1", 32'(addr1), 32'(8'(8'hFE + e.rel)));
        nwrites++;
        last_addr0 = addr0;
        last_addr1 = addr1;
        wlog.push_back({addr0, wdata0});
      end else begin
        chk("we_idle0", 32'(we0), 32'd0);
        chk("we_idle1", 32'(we1), 32'd0);
      end
      chk("core_rst_vs_done", 32'(crst0), 32'(!done0));
    end
  end

  // Drive the stream with random idle gaps; the model predicts a write in the cycle
  // right after every fourth data byte is accepted.
  task automatic send(input int gap);
    int n;
    n = 0;
    for (int i = 0; i < stream.size(); i++) begin
      int   tries;
      logic acc;
      tries = 0;
      acc   = 1'b0;
      while (!acc) begin
        if (tries > 60) begin
          chk("accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
        tries++;
        if ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end else begin
          in_valid = 1'b1;
          in_data  = stream[i];
          acc      = ready0;
        end
        @(posedge clk);
        #1;
      end
      if (i == 0) n = int'(stream[0]);
      else if (i <= 4 * n && i % 4 == 0)
        q.push_back('{word: {stream[i], stream[i-1], stream[i-2], stream[i-3]}, rel: i / 4 - 1, cyc: cyc});
    end
    in_valid = 1'b0;
  endtask

  function automatic bit exp_good();
    int         n;
    logic [7:0] x;
    n = int'(stream[0]);
    if (n == 0) return 1'b0;
    x = 8'd0;
    for (int i = 1; i <= 4 * n; i++) x ^= stream[i];
    return x == stream[4 * n + 1];
  endfunction

  task automatic build(input int n, input bit good);
    logic [7:0] x;
    x = 8'd0;
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      stream.push_back(8'($urandom));
      x ^= stream[stream.size() - 1];
    end
    stream.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic check_end(input bit good);
    @(negedge clk);
    chk("done0", 32'(done0), 32'(good));
    chk("err0", 32'(err0), 32'(!good));
    chk("core_rst0", 32'(crst0), 32'(!good));
    chk("in_ready0", 32'(ready0), 32'd0);
    chk("done1", 32'(done1), 32'(good));
    chk("err1", 32'(err1), 32'(!good));
    chk("pending_writes", 32'(q.size()), 32'd0);
  endtask

  // Bytes offered in a terminal state must be refused.
  task automatic offer(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("ready_terminal", 32'(ready0), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         nw;
    logic [39:0] ref_log[$];
    logic [7:0]  saved[$];
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(ready0), 32'd1);
    chk("rst_im_we", 32'(we0), 32'd0);
    chk("rst_im_addr0", 32'(addr0), 32'h00);
    chk("rst_im_addr1", 32'(addr1), 32'hFE);
    chk("rst_im_wdata", wdata0, 32'd0);
    chk("rst_core_rst", 32'(crst0), 32'd1);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1;

    // Basic load
    stream = '{8'd1, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
    chk("s1_model_good", 32'(exp_good()), 32'd1);
    nw = nwrites;
    send(0);
    check_end(1'b1);
    chk("s1_wdata", wdata0, 32'h00500013);
    chk("s1_writes", 32'(nwrites - nw), 32'd1);
    chk("s1_addr", 32'(last_addr0), 32'h00);
    offer(5);
    chk("s1_done_held", 32'(done0), 32'd1);

    // Bad checksum
    do_reset();
    stream = '{8'd2, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h01};
    nw = nwrites;
    send(0);
    check_end(1'b0);
    chk("s2_wdata", wdata0, 32'h11111111);
    chk("s2_writes", 32'(nwrites - nw), 32'd2);
    chk("s2_last_addr", 32'(last_addr0), 32'h01);
    offer(3);
    chk("s2_err_held", 32'(err0), 32'd1);

    // Zero count
    do_reset();
    stream = '{8'd0};
    nw = nwrites;
    send(0);
    check_end(1'b0);
    chk("s3_writes", 32'(nwrites - nw), 32'd0);

    // Reset mid-load, then a fresh load
    do_reset();
    stream.delete();
    stream.push_back(8'd3);
    for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
    nw = nwrites;
    send(0);
    do_reset();
    chk("s4_partial_writes", 32'(nwrites - nw), 32'd1);
    stream = '{8'd1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send(0);
    check_end(1'b1);
    chk("s4_wdata", wdata0, 32'hDDCCBBAA);
    chk("s4_addr", 32'(last_addr0), 32'h00);
    chk("s4_writes", 32'(nwrites - nw), 32'd2);

    // Address wrap on the 0xFE instance
    do_reset();
    build(3, 1'b1);
    nw = nwrites;
    send(30);
    check_end(1'b1);
    chk("s5_writes", 32'(nwrites - nw), 32'd3);
    chk("s5_wrap_addr", 32'(last_addr1), 32'h00);

    // Throttled run must produce the same writes as the gap-free run
    do_reset();
    build(4, 1'b1);
    saved = stream;
    wlog.delete();
    send(0);
    check_end(1'b1);
    ref_log = wlog;
    do_reset();
    stream = saved;
    wlog.delete();
    send(45);
    check_end(1'b1);
    offer(4);
    chk("s6_log_size", 32'(wlog.size()), 32'(ref_log.size()));
    for (int i = 0; i < wlog.size() && i < ref_log.size(); i++)
      chk("s6_log_word", wlog[i][31:0], ref_log[i][31:0]);

    // Random streams
    for (int t = 0; t < 8; t++) begin
      do_reset();
      build($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      send($urandom_range(0, 50));
      check_end(exp_good());
    end

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width; matches the 8-bit program counter.
REQ-002 Parameter START_ADDR, default 0: word address of the first loaded instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  incoming program byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 im_wdata  output  32  assembled instruction word.
REQ-011 core_rst  output  1  active-high reset driven to the processor core.
REQ-012 done  output  1  load completed, checksum good.
REQ-013 err  output  1  load failed.

Function
REQ-014 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_data SHALL be ignored otherwise.
REQ-015 The stream format SHALL be: 1 count byte N, then 4*N data bytes, then 1 checksum byte.
REQ-016 The states SHALL be IDLE, LOAD, CHECK, DONE and ERROR.
REQ-017 in_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in DONE and ERROR.
REQ-018 IDLE: on accepting N=0, the next state SHALL be ERROR; on accepting N=1..255, N SHALL be latched, address set to START_ADDR, and the next state SHALL be LOAD.
REQ-019 LOAD SHALL assemble words little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-020 On the cycle after the 4th byte of a word transfers, im_we SHALL be 1 for exactly one cycle, with im_addr at the current address and im_wdata at the full word.
REQ-021 The address SHALL increment by 1 after each write, modulo 2^ADDR_W (wrap from all-ones to 0 without flagging).
REQ-022 After the N-th word's 4th byte transfers, the next state SHALL be CHECK.
REQ-023 The running checksum SHALL be the XOR of all 4*N data bytes; the count byte SHALL be excluded.
REQ-024 CHECK: on accepting a byte equal to the checksum, the next state SHALL be DONE; on any other value, the next state SHALL be ERROR.
REQ-025 The im_we write for the last word SHALL occur in the cycle after its 4th byte, independent of the CHECK handshake, and SHALL never be dropped.
REQ-026 In DONE: done=1, core_rst=0, err=0. In every other state: core_rst=1 and done=0.
REQ-027 err SHALL be 1 only in ERROR.
REQ-028 DONE and ERROR SHALL be held until rst; bytes presented in those states SHALL be ignored.
REQ-029 Latency: core_rst SHALL fall on the first rising edge after the good checksum byte transfers, i.e. in the same cycle done rises.
REQ-030 im_we SHALL be 0 in all cycles other than those required by REQ-020.
REQ-031 in_valid held high with back-to-back bytes SHALL be sustained at 1 byte per cycle with no bubbles.

Reset
REQ-032 While rst=1 at a rising edge, the state SHALL become IDLE.
REQ-033 Reset values: in_ready=1, im_we=0, im_addr=START_ADDR, im_wdata=0, core_rst=1, done=0, err=0.
REQ-034 Reset mid-load SHALL discard partial words, the checksum and the count.
REQ-035 Words already written before a mid-load reset SHALL not be retracted.
REQ-036 After reset, the next accepted byte SHALL be treated as a new count byte.

Verification
REQ-037 Scenario 1, basic load: send N=1, bytes 13 00 50 00, checksum 0x43 -> one im_we with addr 0x00 and wdata 0x00500013; then done=1, core_rst=0, err=0.
REQ-038 Scenario 2, bad checksum: send N=2, eight bytes 0x11, checksum 0x01 -> two writes at 0x00 and 0x01, each wdata 0x11111111; then err=1, core_rst stays 1, in_ready=0.
REQ-039 Scenario 3, zero count: send N=0 -> err=1 the next cycle, with no im_we.
REQ-040 Scenario 4, reset mid-load: N=3, 6 data bytes, then rst for 1 cycle; then N=1, AA BB CC DD, checksum 0x00 -> a single write at 0x00 with wdata 0xDDCCBBAA, then done=1.
REQ-041 Scenario 5, address wrap: START_ADDR=0xFE, N=3, checksum correct -> writes at 0xFE, 0xFF, 0x00.
REQ-042 Scenario 6, throttling: random in_valid gaps, and bytes presented in DONE state -> identical memory writes to the gap-free run; bytes offered in DONE are not accepted and cause no writes.
